// File: rtl/capture_ctrl_if.sv
// Host/RAM-side bundle of the logic-analyzer capture sequencer.
interface capture_ctrl_if #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned HOLDOFF_WIDTH = 10
);
  logic                     i_arm;
  logic                     i_trigger;
  logic [HOLDOFF_WIDTH-1:0] i_holdoff;
  logic                     i_rd_en;
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    waddr;
  logic                     primed;
  logic                     triggered;
  logic                     stopped;
  logic [ADDR_WIDTH-1:0]    trig_addr;
  logic [ADDR_WIDTH-1:0]    raddr;
  logic                     rd_valid;
  logic                     rd_last;

  // Host / config side.
  modport master (
    output i_arm, i_trigger, i_holdoff, i_rd_en,
    input  wr_en, waddr, primed, triggered, stopped, trig_addr, raddr, rd_valid, rd_last
  );

  // Capture sequencer side.
  modport slave (
    input  i_arm, i_trigger, i_holdoff, i_rd_en,
    output wr_en, waddr, primed, triggered, stopped, trig_addr, raddr, rd_valid, rd_last
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: arm, pre-trigger fill, primed, post-trigger holdoff,
// stop, then oldest-first readout of the circular sample RAM.
module capture_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned HOLDOFF_WIDTH = 10
) (
  input  logic           clk,
  input  logic           reset,
  capture_ctrl_if.slave  bus
);
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned HW = HOLDOFF_WIDTH;
  localparam int unsigned CW = (HW > AW) ? HW : AW;
  localparam logic [AW-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PRIMED, S_HOLDOFF, S_STOPPED
  } state_e;

  state_e        state_q;
  logic          wr_en_q, primed_q, triggered_q, stopped_q, rd_valid_q, rd_last_q;
  logic [AW-1:0] waddr_q, trig_addr_q, raddr_q;
  logic [AW-1:0] hc_q, hcnt_q, rcnt_q;

  logic [CW-1:0] hold_ext_c;
  logic [AW-1:0] hc_c;
  logic [AW-1:0] waddr_inc_c, hcnt_inc_c, rcnt_inc_c;

  // Holdoff clamped to D-1 so the trigger sample is never overwritten.
  always_comb begin
    hold_ext_c  = CW'(bus.i_holdoff);
    hc_c        = (hold_ext_c > CW'(ADDR_MAX)) ? ADDR_MAX : AW'(hold_ext_c);
    waddr_inc_c = waddr_q + AW'(1);
    hcnt_inc_c  = hcnt_q + AW'(1);
    rcnt_inc_c  = rcnt_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_en_q     <= 1'b0;
      waddr_q     <= '0;
      primed_q    <= 1'b0;
      triggered_q <= 1'b0;
      stopped_q   <= 1'b0;
      trig_addr_q <= '0;
      raddr_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      hc_q        <= '0;
      hcnt_q      <= '0;
      rcnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_arm) begin
            state_q <= S_FILL;
            wr_en_q <= 1'b1;
            waddr_q <= '0;
          end
        end

        S_FILL: begin
          waddr_q <= waddr_inc_c;
          if (waddr_q == ADDR_MAX) begin
            state_q  <= S_PRIMED;
            primed_q <= 1'b1;
          end
        end

        S_PRIMED: begin
          waddr_q <= waddr_inc_c;
          if (bus.i_trigger) begin
            trig_addr_q <= waddr_q;
            triggered_q <= 1'b1;
            hc_q        <= hc_c;
            hcnt_q      <= '0;
            if (hc_c == '0) begin
              state_q    <= S_STOPPED;
              wr_en_q    <= 1'b0;
              stopped_q  <= 1'b1;
              rd_valid_q <= 1'b1;
              raddr_q    <= waddr_inc_c;
              rcnt_q     <= '0;
              rd_last_q  <= 1'b0;
            end else begin
              state_q <= S_HOLDOFF;
            end
          end
        end

        S_HOLDOFF: begin
          waddr_q <= waddr_inc_c;
          hcnt_q  <= hcnt_inc_c;
          // The next-write address after the final holdoff write is the oldest sample.
          if (hcnt_inc_c == hc_q) begin
            state_q    <= S_STOPPED;
            wr_en_q    <= 1'b0;
            stopped_q  <= 1'b1;
            rd_valid_q <= 1'b1;
            raddr_q    <= waddr_inc_c;
            rcnt_q     <= '0;
            rd_last_q  <= 1'b0;
          end
        end

        S_STOPPED: begin
          if (bus.i_rd_en) begin
            if (rd_last_q) begin
              state_q     <= S_IDLE;
              waddr_q     <= '0;
              primed_q    <= 1'b0;
              triggered_q <= 1'b0;
              stopped_q   <= 1'b0;
              rd_valid_q  <= 1'b0;
              rd_last_q   <= 1'b0;
              raddr_q     <= '0;
              rcnt_q      <= '0;
            end else begin
              raddr_q   <= raddr_q + AW'(1);
              rcnt_q    <= rcnt_inc_c;
              rd_last_q <= (rcnt_inc_c == ADDR_MAX);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.waddr     = waddr_q;
  assign bus.primed    = primed_q;
  assign bus.triggered = triggered_q;
  assign bus.stopped   = stopped_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.raddr     = raddr_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed vector bench for capture_ctrl with D=16, 5-bit holdoff.
module tb_capture_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned HW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  capture_ctrl_if #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) bus ();
  capture_ctrl #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       wr;
    logic [3:0] wa;
    logic       pr;
    logic       tg;
    logic       st;
    logic       rv;
    logic       rl;
    logic [3:0] ra;
    logic [3:0] ta;
  } out_t;

  typedef struct {
    logic       rst;
    logic       arm;
    logic       trig;
    logic [4:0] hold;
    logic       rd;
    out_t       e;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t mk(input int wr, input int wa, input int pr, input int tg,
                              input int st, input int rv, input int rl, input int ra,
                              input int ta);
    out_t o;
    o.wr = 1'(wr); o.wa = 4'(wa); o.pr = 1'(pr); o.tg = 1'(tg); o.st = 1'(st);
    o.rv = 1'(rv); o.rl = 1'(rl); o.ra = 4'(ra); o.ta = 4'(ta);
    return o;
  endfunction

  function automatic out_t idle_o(input int ta);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, ta);
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("wr=%0d wa=%0d pr=%0d tg=%0d st=%0d rv=%0d rl=%0d ra=%0d ta=%0d",
                     o.wr, o.wa, o.pr, o.tg, o.st, o.rv, o.rl, o.ra, o.ta);
  endfunction

  task automatic add(input int rst, input int arm, input int trig, input int hold,
                     input int rd, input out_t e);
    vec_t v;
    v.rst = 1'(rst); v.arm = 1'(arm); v.trig = 1'(trig);
    v.hold = 5'(hold); v.rd = 1'(rd); v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input int rst, input int arm, input int trig, input int hold,
                       input int rd);
    reset         = 1'(rst);
    bus.i_arm     = 1'(arm);
    bus.i_trigger = 1'(trig);
    bus.i_holdoff = 5'(hold);
    bus.i_rd_en   = 1'(rd);
  endtask

  task automatic cyc_chk(input string name, input out_t e);
    out_t o;
    @(posedge clk);
    #1;
    o.wr = bus.wr_en;    o.wa = bus.waddr;     o.pr = bus.primed;
    o.tg = bus.triggered; o.st = bus.stopped;  o.rv = bus.rd_valid;
    o.rl = bus.rd_last;  o.ra = bus.raddr;     o.ta = bus.trig_addr;
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(o), fmt(e));
    end
  endtask

  // Arm, run the 16-write fill, then idle in PRIMED until waddr == addr.
  task automatic arm_and_prime(input int addr, input int ta);
    drive(0, 1, 0, 0, 0);
    cyc_chk("arm", mk(1, 0, 0, 0, 0, 0, 0, 0, ta));
    for (int k = 1; k < 16; k++) begin
      drive(0, 0, 0, 0, 0);
      cyc_chk("fill", mk(1, k, 0, 0, 0, 0, 0, 0, ta));
    end
    for (int k = 0; k <= addr; k++) begin
      drive(0, 0, 0, 0, 0);
      cyc_chk("prime", mk(1, k, 1, 0, 0, 0, 0, 0, ta));
    end
  endtask

  initial begin
    // Reset, then trigger/read pulses in IDLE do nothing.
    add(1, 0, 0, 0, 0, idle_o(0));
    add(1, 0, 0, 0, 0, idle_o(0));
    add(0, 0, 1, 0, 1, idle_o(0));
    add(0, 0, 1, 0, 1, idle_o(0));
    // Fill with trigger held high: ignored until PRIMED.
    add(0, 1, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k < 16; k++) add(0, 0, 1, 0, 0, mk(1, k, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 0, 0, mk(1, k, 1, 0, 0, 0, 0, 0, 0));
    // Trigger at waddr=3 with holdoff 5; arm/trigger/holdoff changes ignored in HOLDOFF.
    add(0, 0, 1, 5, 0, mk(1, 4, 1, 1, 0, 0, 0, 0, 3));
    for (int k = 5; k <= 8; k++) add(0, 1, 1, 0, 0, mk(1, k, 1, 1, 0, 0, 0, 0, 3));
    add(0, 0, 0, 0, 0, mk(0, 9, 1, 1, 1, 1, 0, 9, 3));
    // Readout from oldest sample (9) with a 3-cycle gap after the 4th accept.
    for (int k = 1; k <= 15; k++) begin
      if (k == 5)
        for (int g = 0; g < 3; g++) add(0, 0, 0, 0, 0, mk(0, 9, 1, 1, 1, 1, 0, 13, 3));
      add(0, 0, 0, 0, 1, mk(0, 9, 1, 1, 1, 1, (k == 15) ? 1 : 0, (9 + k) % 16, 3));
    end
    // Final accept with arm ignored; arm on the first IDLE cycle is honoured.
    add(0, 1, 0, 0, 1, idle_o(3));
    add(0, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 3));
    add(1, 0, 0, 0, 0, idle_o(0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(int'(vecs[i].rst), int'(vecs[i].arm), int'(vecs[i].trig),
            int'(vecs[i].hold), int'(vecs[i].rd));
      cyc_chk($sformatf("vec%0d", i), vecs[i].e);
    end

    // Holdoff 0: stop immediately after the trigger write.
    arm_and_prime(7, 0);
    drive(0, 0, 1, 0, 0);
    cyc_chk("h0_stop", mk(0, 8, 1, 1, 1, 1, 0, 8, 7));
    drive(0, 0, 1, 0, 0);
    cyc_chk("h0_frozen", mk(0, 8, 1, 1, 1, 1, 0, 8, 7));
    drive(1, 0, 0, 0, 0);
    cyc_chk("h0_reset", idle_o(0));

    // Holdoff 20 clamps to 15: wraps all the way round to the trigger address.
    arm_and_prime(7, 0);
    drive(0, 0, 1, 20, 0);
    cyc_chk("h20_trig", mk(1, 8, 1, 1, 0, 0, 0, 0, 7));
    for (int k = 1; k <= 14; k++) begin
      drive(0, 0, 0, 0, 0);
      cyc_chk("h20_hold", mk(1, (8 + k) % 16, 1, 1, 0, 0, 0, 0, 7));
    end
    drive(0, 0, 0, 0, 0);
    cyc_chk("h20_stop", mk(0, 7, 1, 1, 1, 1, 0, 7, 7));
    drive(1, 0, 0, 0, 0);
    cyc_chk("h20_reset", idle_o(0));

    // Reset mid-HOLDOFF (count 2) aborts; a fresh arm fills from 0.
    arm_and_prime(2, 0);
    drive(0, 0, 1, 5, 0);
    cyc_chk("ab_trig", mk(1, 3, 1, 1, 0, 0, 0, 0, 2));
    drive(0, 0, 0, 5, 0);
    cyc_chk("ab_cnt1", mk(1, 4, 1, 1, 0, 0, 0, 0, 2));
    drive(0, 0, 0, 5, 0);
    cyc_chk("ab_cnt2", mk(1, 5, 1, 1, 0, 0, 0, 0, 2));
    drive(1, 1, 1, 5, 1);
    cyc_chk("ab_reset", idle_o(0));
    drive(0, 1, 0, 0, 0);
    cyc_chk("ab_rearm", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0);
    cyc_chk("ab_fill1", mk(1, 1, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture sequencer for the internal logic analyzer. Owns the sample-memory write address and walks one capture through arm, pre-trigger fill, primed, post-trigger holdoff, stop and readout. Drives the capture RAM write port and gives the host a handshaked read-address stream starting at the oldest stored sample. Sits between the host/config registers and the sample RAM.

## Interface
- ADDR_WIDTH, default 10: sample RAM address width; depth D = 2^ADDR_WIDTH.
- HOLDOFF_WIDTH, default 10: width of i_holdoff.
- clk  in  1  single capture clock.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- i_arm  in  1  start-capture request; honoured only in IDLE.
- i_trigger  in  1  trigger condition; sampled only in PRIMED.
- i_holdoff  in  HOLDOFF_WIDTH  post-trigger sample count H; latched on the trigger cycle.
- i_rd_en  in  1  readout accept; one sample consumed per cycle with rd_valid=1.
- wr_en  out  1  RAM write enable.
- waddr  out  ADDR_WIDTH  RAM write address.
- primed  out  1  pre-trigger history full; trigger armed.
- triggered  out  1  trigger accepted.
- stopped  out  1  writing finished; memory frozen.
- trig_addr  out  ADDR_WIDTH  address of the trigger sample.
- raddr  out  ADDR_WIDTH  RAM read address.
- rd_valid  out  1  raddr valid for readout.
- rd_last  out  1  current raddr is the final (D-th) sample.

## Operation
- States: IDLE, FILL, PRIMED, HOLDOFF, STOPPED.
- IDLE: wr_en=0. i_arm=1 -> FILL, waddr<=0.
- FILL: wr_en=1, waddr increments by 1 each cycle. After the write to address D-1 -> PRIMED, waddr wraps to 0. i_trigger ignored.
- PRIMED: wr_en=1, waddr increments modulo D. i_trigger=1 -> trig_addr<=waddr, Hc<=min(i_holdoff, D-1), post-trigger counter<=0. Next state is STOPPED if Hc=0, else HOLDOFF.
- HOLDOFF: wr_en=1, waddr increments modulo D, counter increments per write. The write that brings the count to Hc -> STOPPED. The clamp to D-1 guarantees the trigger sample is never overwritten.
- STOPPED: wr_en=0, waddr frozen at the next-write address, which is the oldest sample. rd_valid=1. On entry raddr<=waddr and the read counter clears.
- Readout: each cycle with i_rd_en=1 increments raddr modulo D and the read counter. rd_last=1 when the read counter equals D-1. Accepting rd_last -> IDLE.
- Flags: primed=1 in PRIMED, HOLDOFF and STOPPED. triggered=1 in HOLDOFF and STOPPED. stopped=1 in STOPPED only. All three clear on return to IDLE.
- raddr=0 and rd_valid=0 outside STOPPED. trig_addr holds its value until the next trigger or reset.
- i_arm outside IDLE is ignored. Abort is by reset only.
- i_trigger and i_holdoff are ignored outside the PRIMED trigger cycle. Changing i_holdoff during HOLDOFF has no effect.

## Timing
- Reset: next edge gives state IDLE. wr_en, waddr, primed, triggered, stopped, trig_addr, raddr, rd_valid and rd_last are all 0. Reset in any state, including mid-HOLDOFF or mid-readout, behaves the same; reset has priority over every other input.
- All outputs are registered or decoded from state. No combinational input-to-output path.
- i_arm at cycle N: wr_en=1 and waddr=0 at N+1. Last fill write (waddr=D-1) at N+D. primed=1 and waddr=0 at N+D+1.
- Trigger at cycle T (state PRIMED, waddr=A):
  - triggered=1 and trig_addr=A at T+1.
  - Hc>0: writes at T+1..T+Hc to addresses A+1..A+Hc. stopped=1 and wr_en=0 at T+Hc+1, waddr=(A+Hc+1) mod D.
  - Hc=0: stopped=1 at T+1, waddr=(A+1) mod D.
- Readout: rd_valid=1 from the first STOPPED cycle; raddr updates the cycle after each accept. After the rd_last accept, state is IDLE next cycle and all flags are 0.
- i_arm in the same cycle as the final accept is ignored. i_arm is honoured from the first IDLE cycle onward.

## Test plan
All scenarios use ADDR_WIDTH=4 (D=16), HOLDOFF_WIDTH=5.
- Reset/idle: reset 2 cycles, then pulse i_trigger and i_rd_en in IDLE -> all outputs remain 0.
- Fill/prime: i_arm at cycle 0, i_trigger=1 throughout FILL -> wr_en=1 with waddr 0..15 over cycles 1..16; primed=1, waddr=0 at cycle 17; triggered stays 0.
- Trigger with holdoff 5: trigger when waddr=3 -> trig_addr=3, triggered next cycle; 5 further writes to 4..8; stopped=1, wr_en=0, waddr=9, raddr=9, rd_valid=1.
- Holdoff bounds: H=0 with trigger at waddr=7 -> stopped next cycle, waddr=8. H=20 with trigger at waddr=7 -> clamped to 15, writes 8..15 then 0..6, waddr=7=trig_addr.
- Readout: after the H=5 case, 16 accepts with a 3-cycle i_rd_en gap after the 4th -> raddr 9..15,0..8, raddr holds during the gap, rd_last only at raddr=8, IDLE next cycle with flags clear.
- Abort/ignored arm: i_arm during HOLDOFF -> no effect. reset at HOLDOFF count 2 -> next cycle all outputs 0. New i_arm -> normal fill from waddr=0.
